fx_alu_v2: RTL
==============

Name: fx_alu_v2

Overview:
Second-generation parametrised fixed-point ALU for the signed Q(INT_W).(FRAC_W) datapath. It adds proper saturation of the 36-bit-class MAC accumulator and round-half-up output narrowing. It generalises the bit-group transpose to any DATA_W/GRP_W rows, sequenced by an explicit FSM. It sits between the instruction feeder (valid/busy handshake) and the result sink (o_out_valid strobe).

Parameters:
INST_W, 4, opcode width
INT_W, 6, integer bits of operand/result
FRAC_W, 10, fraction bits of operand/result
ACC_INT_W, 16, accumulator integer bits
ACC_FRAC_W, 20, accumulator fraction bits (must be 2*FRAC_W)
GRP_W, 2, transpose field width; DATA_W must be a multiple of GRP_W
Derived localparams: DATA_W=INT_W+FRAC_W, ACC_W=ACC_INT_W+ACC_FRAC_W, ROWS=DATA_W/GRP_W.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-high
i_in_valid  in  1  instruction/operands valid
o_busy  out  1  high = input not accepted this cycle
i_inst  in  INST_W  opcode
i_data_a  in  DATA_W  signed operand A
i_data_b  in  DATA_W  signed operand B
o_out_valid  out  1  one-cycle result strobe
o_data  out  DATA_W  result

Behaviour:
- Reset (i_rst=1, async): o_data=0, o_out_valid=0, o_busy=1, acc=0, row counter=0, FSM=IDLE. o_busy falls to 0 on the first i_clk edge after i_rst deasserts.
- Accept: an input is accepted when i_in_valid && !o_busy. Inputs offered while busy are ignored; no queueing.
- Single-cycle ops (IDLE only): result registered, o_out_valid=1 exactly one cycle after acceptance. o_busy stays 0, so back-to-back issue is allowed.
  0x0 ADD: saturating; clamp to 0x7FFF/0x8000 at DATA_W=16.
  0x1 SUB: saturating. B=most-negative must saturate correctly, not wrap.
  0x2 MAC: acc = sat_ACC(acc + a*b), full-precision signed product. o_data = round(acc).
  0x3 MACCLR: acc = a*b, discarding the old acc. Output as MAC.
  0x4 CLZ: leading zeros of A, 0..DATA_W. A=0 gives DATA_W.
  0x5 ROTR: rotate A right by B mod DATA_W.
  0x9 TRANSPOSE: starts a collect sequence; see FSM.
  Other opcodes: o_data=0, o_out_valid=1, acc unchanged.
- Rounding: take acc[ACC_FRAC_W-FRAC_W +: DATA_W] and add 1 if bit [ACC_FRAC_W-FRAC_W-1] is set (round half up). Saturate to DATA_W if the upper acc bits are not a sign extension or the increment overflows.
- sat_ACC: clamp to ACC_W max/min on signed overflow. acc holds its value through all non-MAC ops.
- FSM IDLE->COLLECT: on accepted TRANSPOSE, i_data_a is stored as row 0 and cnt=1. No o_out_valid is produced.
- COLLECT: o_busy=0. Each accepted input stores i_data_a as row[cnt] and increments cnt; i_inst is ignored. When row ROWS-1 is stored, go to EMIT; o_busy=1 from the next cycle.
- EMIT: ROWS consecutive cycles, o_out_valid=1 each.
  Output j (j=0..ROWS-1): field i = bits [DATA_W-1-GRP_W*i -: GRP_W], set to row[i] field j.
  After the last output, go to IDLE with o_busy=0 on the next cycle.
- Reset mid-COLLECT or mid-EMIT: abort immediately. No further o_out_valid, rows discarded, and acc is cleared.

Optional Feature:
FX_ALU_STATUS_EN:
- Defined: adds output o_sat (1 bit, reset 0). It is registered alongside o_out_valid and is high when that result was clamped: ADD/SUB saturation, acc saturation, or rounding saturation.
- Undefined: the port is absent and there is no saturation-tracking logic.

Decomposition:
- Package fx_alu_pkg: opcode localparams, FSM state enum (IDLE/COLLECT/EMIT), and DATA_W/ACC_W saturation constants (max/min).
- Sub-module fx_mac_sat: product, saturating accumulate and rounding, combinational next-acc plus the acc register.
- Top module keeps the FSM, row buffer and the simple ops.

Test Plan:
- ADD 0x7C00 + 0x0800 -> o_data=0x7FFF one cycle later. SUB 0x0000 - 0x8000 -> 0x7FFF.
- MACCLR a=0x0600, b=0x0400 -> 0x0600. Then MAC with the same operands -> 0x0C00. Then MAC a=0x7FFF, b=0x7FFF repeated 64 times -> pinned at 0x7FFF.
- Rounding: MACCLR a=0x0001, b=0x0200 (acc = 2^-11) -> 0x0001. MACCLR a=0x0001, b=0x0100 -> 0x0000.
- CLZ 0x0010 -> 11; CLZ 0x0000 -> 16. ROTR 0x0001 by 17 -> 0x8000.
- TRANSPOSE (DATA_W=16, GRP_W=2): rows 0xFFFF then 7×0x0000.
  Response: 8 consecutive valid cycles, each 0xC000; o_busy=1 throughout EMIT.
  A second instruction offered during EMIT is not accepted.
- Assert i_rst during EMIT cycle 3: o_out_valid=0 and o_busy=1 immediately. After deassert, IDLE, and MAC a=0x0400, b=0x0400 -> 0x0400 (acc was cleared).

Source files
------------

// File: rtl/fx_alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : fx_alu_pkg
// Brief   : Opcodes, FSM states and saturation bounds shared by fx_alu_v2.
// Rev     : 1.0  initial release
// ============================================================================
package fx_alu_pkg;

    localparam logic [3:0] c_OP_ADD       = 4'h0;
    localparam logic [3:0] c_OP_SUB       = 4'h1;
    localparam logic [3:0] c_OP_MAC       = 4'h2;
    localparam logic [3:0] c_OP_MACCLR    = 4'h3;
    localparam logic [3:0] c_OP_CLZ       = 4'h4;
    localparam logic [3:0] c_OP_ROTR      = 4'h5;
    localparam logic [3:0] c_OP_TRANSPOSE = 4'h9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    // Two's-complement bounds of a w-bit word (w <= 64); callers truncate to w bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fx_mac_sat.sv
`default_nettype none
// ============================================================================
// Module : fx_mac_sat
// Brief  : Signed MAC with saturating accumulator and round-half-up narrowing.
//          Optional o_sat_next under FX_ALU_STATUS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fx_mac_sat
    import fx_alu_pkg::*;
#(
    parameter int INT_W      = 6,
    parameter int FRAC_W     = 10,
    parameter int ACC_INT_W  = 16,
    parameter int ACC_FRAC_W = 20,
    localparam int DATA_W    = INT_W + FRAC_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_round_next
`ifdef FX_ALU_STATUS_EN
    ,
    output logic              o_sat_next
`endif
);

    localparam int ACC_W  = ACC_INT_W + ACC_FRAC_W;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SH     = ACC_FRAC_W - FRAC_W;

    localparam logic [ACC_W-1:0]  c_ACC_MAX  = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0]  c_ACC_MIN  = ACC_W'(sat_min(ACC_W));
    localparam logic [DATA_W-1:0] c_DATA_MAX = DATA_W'(sat_max(DATA_W));
    localparam logic [DATA_W-1:0] c_DATA_MIN = DATA_W'(sat_min(DATA_W));

    logic [ACC_W-1:0]         r_acc;
    logic signed [PROD_W-1:0] w_a_ext;
    logic signed [PROD_W-1:0] w_b_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]         w_prod_ext;
    logic [ACC_W-1:0]         w_base;
    logic [ACC_W:0]           w_sum;
    logic                     w_acc_ovf;
    logic [ACC_W-1:0]         w_acc_next;
    logic                     w_hi_ok;
    logic [DATA_W:0]          w_rnd;
    logic                     w_rnd_ovf;

    assign w_a_ext    = PROD_W'($signed(i_a));
    assign w_b_ext    = PROD_W'($signed(i_b));
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_base     = i_clr ? '0 : r_acc;

    assign w_sum      = {w_base[ACC_W-1], w_base} + {w_prod_ext[ACC_W-1], w_prod_ext};
    assign w_acc_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_next = w_acc_ovf ? (w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX) : w_sum[ACC_W-1:0];

    // Narrowing is only exact when everything above the output window is sign extension.
    assign w_hi_ok   = (&w_acc_next[ACC_W-1:SH+DATA_W-1]) | ~(|w_acc_next[ACC_W-1:SH+DATA_W-1]);
    assign w_rnd     = {w_acc_next[SH+DATA_W-1], w_acc_next[SH +: DATA_W]}
                     + (DATA_W+1)'(w_acc_next[SH-1]);
    assign w_rnd_ovf = w_rnd[DATA_W] ^ w_rnd[DATA_W-1];

    assign o_round_next = !w_hi_ok  ? (w_acc_next[ACC_W-1] ? c_DATA_MIN : c_DATA_MAX)
                        : w_rnd_ovf ? c_DATA_MAX
                        : w_rnd[DATA_W-1:0];

`ifdef FX_ALU_STATUS_EN
    assign o_sat_next = w_acc_ovf | ~w_hi_ok | w_rnd_ovf;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fx_alu_v2.sv
`default_nettype none
// ============================================================================
// Module : fx_alu_v2
// Brief  : Fixed-point ALU with saturating MAC and sequenced bit-group transpose.
//          Optional o_sat status output under FX_ALU_STATUS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fx_alu_v2
    import fx_alu_pkg::*;
#(
    parameter int INST_W     = 4,
    parameter int INT_W      = 6,
    parameter int FRAC_W     = 10,
    parameter int ACC_INT_W  = 16,
    parameter int ACC_FRAC_W = 20,
    parameter int GRP_W      = 2,
    localparam int DATA_W    = INT_W + FRAC_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_busy,
    input  logic [INST_W-1:0] i_inst,
    input  logic [DATA_W-1:0] i_data_a,
    input  logic [DATA_W-1:0] i_data_b,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_data
`ifdef FX_ALU_STATUS_EN
    ,
    output logic              o_sat
`endif
);

    localparam int ROWS  = DATA_W / GRP_W;
    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0]  c_LAST_ROW = CNT_W'(ROWS - 1);
    localparam logic [DATA_W-1:0] c_DATA_MAX = DATA_W'(sat_max(DATA_W));
    localparam logic [DATA_W-1:0] c_DATA_MIN = DATA_W'(sat_min(DATA_W));

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rows [ROWS];
    logic              r_busy;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    logic              w_accept;
    logic              w_mac_en;
    logic              w_mac_clr;
    logic [DATA_W-1:0] w_mac_round;
    logic [DATA_W:0]   w_add;
    logic [DATA_W:0]   w_sub;
    logic              w_add_ovf;
    logic              w_sub_ovf;
    logic [DATA_W-1:0] w_clz;
    logic [31:0]       w_b32;
    logic [31:0]       w_sh;
    logic [DATA_W-1:0] w_rot;
    logic [DATA_W-1:0] w_op_result;
    logic [DATA_W-1:0] w_tr;

    assign w_accept  = i_in_valid & ~r_busy;
    assign w_mac_clr = (i_inst == INST_W'(c_OP_MACCLR));
    assign w_mac_en  = w_accept & (r_state == ST_IDLE)
                     & ((i_inst == INST_W'(c_OP_MAC)) | w_mac_clr);

`ifdef FX_ALU_STATUS_EN
    logic w_mac_sat;
    logic w_op_sat;
    logic r_sat;
`endif

    fx_mac_sat #(
        .INT_W      (INT_W),
        .FRAC_W     (FRAC_W),
        .ACC_INT_W  (ACC_INT_W),
        .ACC_FRAC_W (ACC_FRAC_W)
    ) u_mac (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (w_mac_en),
        .i_clr        (w_mac_clr),
        .i_a          (i_data_a),
        .i_b          (i_data_b),
        .o_round_next (w_mac_round)
`ifdef FX_ALU_STATUS_EN
        ,
        .o_sat_next   (w_mac_sat)
`endif
    );

    // One extra bit makes B = most-negative subtract correctly instead of wrapping.
    assign w_add     = {i_data_a[DATA_W-1], i_data_a} + {i_data_b[DATA_W-1], i_data_b};
    assign w_sub     = {i_data_a[DATA_W-1], i_data_a} - {i_data_b[DATA_W-1], i_data_b};
    assign w_add_ovf = w_add[DATA_W] ^ w_add[DATA_W-1];
    assign w_sub_ovf = w_sub[DATA_W] ^ w_sub[DATA_W-1];

    assign w_b32 = 32'(i_data_b);
    assign w_sh  = w_b32 % 32'(DATA_W);
    assign w_rot = DATA_W'({i_data_a, i_data_a} >> w_sh);

    always_comb begin
        w_clz = DATA_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            if (i_data_a[i]) w_clz = DATA_W'(DATA_W - 1 - i);
        end
    end

    always_comb begin
        w_op_result = '0;
        case (i_inst)
            INST_W'(c_OP_ADD):    w_op_result = w_add_ovf ? (w_add[DATA_W] ? c_DATA_MIN : c_DATA_MAX)
                                                          : w_add[DATA_W-1:0];
            INST_W'(c_OP_SUB):    w_op_result = w_sub_ovf ? (w_sub[DATA_W] ? c_DATA_MIN : c_DATA_MAX)
                                                          : w_sub[DATA_W-1:0];
            INST_W'(c_OP_MAC),
            INST_W'(c_OP_MACCLR): w_op_result = w_mac_round;
            INST_W'(c_OP_CLZ):    w_op_result = w_clz;
            INST_W'(c_OP_ROTR):   w_op_result = w_rot;
            default:              w_op_result = '0;
        endcase
    end

`ifdef FX_ALU_STATUS_EN
    always_comb begin
        w_op_sat = 1'b0;
        case (i_inst)
            INST_W'(c_OP_ADD):    w_op_sat = w_add_ovf;
            INST_W'(c_OP_SUB):    w_op_sat = w_sub_ovf;
            INST_W'(c_OP_MAC),
            INST_W'(c_OP_MACCLR): w_op_sat = w_mac_sat;
            default:              w_op_sat = 1'b0;
        endcase
    end
`endif

    // Output j gathers field j of every row; row i lands in field i.
    always_comb begin
        w_tr = '0;
        for (int i = 0; i < ROWS; i++) begin
            w_tr[DATA_W-1-GRP_W*i -: GRP_W] = r_rows[i][DATA_W-1-GRP_W*int'(r_cnt) -: GRP_W];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_data  <= '0;
            for (int r = 0; r < ROWS; r++) r_rows[r] <= '0;
`ifdef FX_ALU_STATUS_EN
            r_sat   <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
`ifdef FX_ALU_STATUS_EN
            r_sat   <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_accept) begin
                        if (i_inst == INST_W'(c_OP_TRANSPOSE)) begin
                            r_rows[0] <= i_data_a;
                            r_cnt     <= CNT_W'(1);
                            r_state   <= ST_COLLECT;
                        end else begin
                            r_valid <= 1'b1;
                            r_data  <= w_op_result;
`ifdef FX_ALU_STATUS_EN
                            r_sat   <= w_op_sat;
`endif
                        end
                    end
                end
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_rows[r_cnt] <= i_data_a;
                        if (r_cnt == c_LAST_ROW) begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_EMIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    r_valid <= 1'b1;
                    r_data  <= w_tr;
                    // Busy stays high through the last output; IDLE drops it a cycle later.
                    if (r_cnt == c_LAST_ROW) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_out_valid = r_valid;
    assign o_data      = r_data;
`ifdef FX_ALU_STATUS_EN
    assign o_sat       = r_sat;
`endif

endmodule
`default_nettype wire
